// File: rtl/cic3_decim_filter.sv
// Third-order CIC decimation filter for a 1-bit sigma-delta bitstream.
// Three integrators run at the input rate. A decimation counter fires a
// strobe once every 2**DEC_LOG2 clocks. On each strobe a three-stage comb
// forms the output sample. All arithmetic is modulo 2**OUT_WIDTH; the
// integrators wrap by design and the comb differences cancel the wrap.
// Optional build macro CIC3_DIGITAL_MONITOR_EN adds a registered debug
// tap (monitor_out) that is selected by digital_monitor_sel.
module cic3_decim_filter #(
  parameter int DEC_LOG2  = 8,
  parameter int OUT_WIDTH = 25
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in,
`ifdef CIC3_DIGITAL_MONITOR_EN
  input  logic [3:0]           digital_monitor_sel,
  output logic [OUT_WIDTH-1:0] monitor_out,
`endif
  output logic [OUT_WIDTH-1:0] out,
  output logic                 out_valid
);

  // Integrator chain
  logic [OUT_WIDTH-1:0] i1_q, i1_d;
  logic [OUT_WIDTH-1:0] i2_q, i2_d;
  logic [OUT_WIDTH-1:0] i3_q, i3_d;

  // Comb delay registers, sampled once per output frame
  logic [OUT_WIDTH-1:0] d1_q, d1_d;
  logic [OUT_WIDTH-1:0] d2_q, d2_d;
  logic [OUT_WIDTH-1:0] d3_q, d3_d;

  // Decimation counter and output registers
  logic [DEC_LOG2-1:0]  cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0] out_q, out_d;
  logic                 valid_q, valid_d;

  // Combinational helpers
  logic [OUT_WIDTH-1:0] in_ext;
  logic                 strobe;
  logic [OUT_WIDTH-1:0] c1, c2, c3;

  // Next-state logic for the integrators, the counter and the comb section
  always_comb begin
    in_ext    = '0;
    in_ext[0] = in;
    strobe    = (cnt_q == {DEC_LOG2{1'b1}});

    i1_d  = i1_q + in_ext;
    i2_d  = i2_q + i1_q;
    i3_d  = i3_q + i2_q;
    cnt_d = cnt_q + DEC_LOG2'(1);

    // The comb uses the registered i3, which is the value before this edge
    c1 = i3_q - d1_q;
    c2 = c1 - d2_q;
    c3 = c2 - d3_q;

    d1_d    = d1_q;
    d2_d    = d2_q;
    d3_d    = d3_q;
    out_d   = out_q;
    valid_d = strobe;

    if (strobe) begin
      d1_d  = i3_q;
      d2_d  = c1;
      d3_d  = c2;
      out_d = c3;
    end
  end

  // State registers; reset clears every stage so that no partial frame survives
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i1_q    <= '0;
      i2_q    <= '0;
      i3_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      d3_q    <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      i1_q    <= i1_d;
      i2_q    <= i2_d;
      i3_q    <= i3_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      d3_q    <= d3_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;

`ifdef CIC3_DIGITAL_MONITOR_EN
  logic [OUT_WIDTH-1:0] mon_q, mon_d;

  // Debug tap selection; unused codes read back as zero
  always_comb begin
    mon_d = '0;
    case (digital_monitor_sel)
      4'd0:    mon_d = i1_q;
      4'd1:    mon_d = i2_q;
      4'd2:    mon_d = i3_q;
      4'd3:    mon_d = c1;
      4'd4:    mon_d = c2;
      4'd5:    mon_d = c3;
      4'd6:    mon_d = OUT_WIDTH'({in, cnt_q});
      default: mon_d = '0;
    endcase
  end

  // Register the tap so that the monitor path does not extend the filter timing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mon_q <= '0;
    end else begin
      mon_q <= mon_d;
    end
  end

  assign monitor_out = mon_q;
`endif

endmodule

// File: tb/tb_cic3_decim_filter.sv
// Directed testbench for cic3_decim_filter (R = 256, 25-bit output).
// The expected values were derived by hand. A constant-one input yields the
// comb outputs C(255,3), then the third differences of C(256m-1,3) with zero
// initial history, and then the full-scale value 2**24.
module tb_cic3_decim_filter;

  localparam int W = 25;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic         in_r  = 1'b0;
  logic         alt   = 1'b0;
  logic [W-1:0] out;
  logic         out_valid;
`ifdef CIC3_DIGITAL_MONITOR_EN
  logic [3:0]   sel = 4'd6;
  logic [W-1:0] mon;
`endif

  int checks   = 0;
  int failures = 0;

  // Constant-one response starting from all-zero state
  int exp_ones [6] = '{2731135, 13915010, 16777215, 16777216, 16777216, 16777216};

  always #5 clk = ~clk;

  cic3_decim_filter #(.DEC_LOG2(8), .OUT_WIDTH(W)) dut (
    .clk                 (clk),
    .reset               (reset),
    .in                  (in_r),
`ifdef CIC3_DIGITAL_MONITOR_EN
    .digital_monitor_sel (sel),
    .monitor_out         (mon),
`endif
    .out                 (out),
    .out_valid           (out_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance clock by clock until out_valid is seen (bounded); n = clocks taken
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (alt) in_r = ~in_r;
    end while (!out_valid && n < 300);
  endtask

  initial begin
    int n;

    // Reset state
    #500;
    check("rst_out", {7'd0, out}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
`ifdef CIC3_DIGITAL_MONITOR_EN
    check("rst_mon", {7'd0, mon}, 32'd0);
`endif
    #500;
    reset = 1'b0;

    // Zero input: zero output and an exact 256-clock period
    for (int k = 0; k < 4; k++) begin
      wait_valid(n);
      check("zero_period", n, 32'd256);
      check("zero_out", {7'd0, out}, 32'd0);
    end

    // Step to constant one, aligned to the start of a frame
    in_r = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_valid(n);
      check("step_period", n, 32'd256);
      check("step_out", {7'd0, out}, exp_ones[k]);
    end

    // Output holds between strobes
    repeat (100) @(posedge clk);
    #1;
    check("hold_out", {7'd0, out}, 32'd16777216);
    check("hold_valid", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset in mid-frame
    #2;
    reset = 1'b1;
    #1;
    check("async_out", {7'd0, out}, 32'd0);
    #20;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_valid(n);
      check("rst_mid_period", n, 32'd256);
      check("rst_mid_out", {7'd0, out}, exp_ones[k]);
    end

    // Reset during the out_valid pulse clears it at once
    #2;
    reset = 1'b1;
    #1;
    check("async_valid", {31'd0, out_valid}, 32'd0);
    check("async_out2", {7'd0, out}, 32'd0);
    #20;

    // Alternating input settles to half scale
    in_r  = 1'b1;
    alt   = 1'b1;
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      wait_valid(n);
      check("alt_period", n, 32'd256);
      if (k >= 3) check("alt_out", {7'd0, out}, 32'd8388608);
    end
    alt = 1'b0;

`ifdef CIC3_DIGITAL_MONITOR_EN
    // Monitor tap: {in, cnt} after ten clocks, then an unused select
    #2;
    reset = 1'b1;
    #20;
    sel   = 4'd6;
    in_r  = 1'b1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mon_cnt", {7'd0, mon}, 32'd265);
    sel = 4'd15;
    @(posedge clk);
    #1;
    check("mon_zero", {7'd0, mon}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cic3_decim_filter.md
Name: cic3_decim_filter

Overview:
- Third-order CIC decimation filter for the 1-bit sigma-delta modulator bitstream in the echip65 readout chain.
- Runs on the 5.12 MHz filter clock (phi1F); modulator samples are taken on the non-overlapping phase.
- Decimates by 256 and delivers a 25-bit unsigned result every 256 clocks (20 kHz output rate).
- A downstream serializer captures the result on its own sclk.

Parameters:
- DEC_LOG2, 8, log2 of decimation ratio R (R = 2**DEC_LOG2 = 256).
- OUT_WIDTH, 25, datapath and output width; must equal 3*DEC_LOG2+1.

Ports:
- clk  input  1  filter clock, rising-edge (5.12 MHz phi1F).
- reset  input  1  asynchronous, active-high reset.
- in  input  1  modulator bitstream; sampled on the rising edge of clk.
- out  output  OUT_WIDTH  decimated filter result, unsigned.
- out_valid  output  1  one-clk pulse in the cycle `out` is updated.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset clears all state to 0: 3 integrators, 3 comb delay registers, decimation counter, out, out_valid.
- Reset deasserted mid-operation restarts the counter from 0; no partial state survives.
- Input mapping: in=1 adds 1, in=0 adds 0, zero-extended to OUT_WIDTH.
- Integrators, updated every clk:
  - i1 <= i1 + in
  - i2 <= i2 + i1
  - i3 <= i3 + i2
  - All use registered old values, modulo 2**OUT_WIDTH, wrap-around intentional, no saturation.
- Decimation counter cnt (DEC_LOG2 bits):
  - Increments every clk and wraps 255->0.
  - Decimation strobe = (cnt == R-1).
- Comb stage, evaluated only on strobe edges, using the current registered i3:
  - c1 = i3 - d1; c2 = c1 - d2; c3 = c2 - d3, all modulo 2**OUT_WIDTH.
  - Delay updates: d1<=i3, d2<=c1, d3<=c2.
  - out <= c3.
- out_valid is high for exactly the clk cycle following each strobe edge, i.e. once per 256 clocks. First pulse comes 256 clocks after reset release.
- `out` holds its value between strobes.
- Gain is R**3 = 2**24; the full-scale result 16777216 fits in 25 bits unsigned.
- Steady state is reached by the 4th out_valid after an input change; earlier outputs are transient.
- No handshake or backpressure: the consumer must sample within 256 clocks.

Optional Feature:
- Macro: CIC3_DIGITAL_MONITOR_EN.
- When defined, two ports are added:
  - digital_monitor_sel input [3:0].
  - monitor_out output OUT_WIDTH, registered on clk and reset to 0.
- monitor_out selection:
  - sel 0: i1.
  - sel 1: i2.
  - sel 2: i3.
  - sel 3: c1.
  - sel 4: c2.
  - sel 5: c3.
  - sel 6: {in, cnt} zero-extended.
  - other values: 0.
- Without the macro: no such ports; filter behaviour identical.

Test Plan:
- Reset held 1000 ns, then released with in=0 constant -> out=0 at every out_valid; out_valid period exactly 256 clk.
- in=1 constant from reset release -> out reaches 16777216 (0x1000000) by the 4th out_valid and stays there.
- in alternating 1,0,1,0 -> out settles to 8388608 (0x800000).
- Step: steady in=0, then switch to in=1 for the remaining run -> out rises monotonically over 3 outputs to 16777216; integrators wrap with no effect on the result.
- Assert reset mid-frame with in=1 -> out, out_valid, and counter go to 0 immediately, asynchronously to clk; after release, next out_valid comes 256 clk later.
- With CIC3_DIGITAL_MONITOR_EN defined and sel=6 -> monitor_out low bits track cnt 0..255; sel=15 -> monitor_out=0.
